sll_sequencer: RTL and testbench

Multi-cycle controller that executes `sll` by borrowing the shared ALU. The ALU has no shifter. When the ALU control decoder raises its sll flag, this block takes over the ALU operand and control inputs for `shamt` cycles. Each cycle it performs acc + acc (a shift left by one) and writes the result back into an internal accumulator. While it does this, it stalls the rest of the processor, then presents the final shifted value for writeback.

---
 rtl/sll_sequencer_if.sv | 35 +++
 rtl/sll_sequencer.sv | 119 +++++++++++
 tb/tb_sll_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sll_sequencer_if.sv
// Purpose: bundles the sll sequencer's control, operand, borrowed-ALU and writeback signals.
// Latency: wires only; no storage.
// Backpressure: none here; the sequencer pushes back through stall.
// Ports (master = control unit/datapath side, slave = sequencer):
//   start, sll_flag, operand, shamt, alu_result    -> sequencer
//   alu_sel, alu_a, alu_b, alu_ctr, stall, busy,
//   done, result                                   <- sequencer
interface sll_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic               sll_flag;
  logic [WIDTH-1:0]   operand;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_sel;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [3:0]         alu_ctr;
  logic               stall;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, sll_flag, operand, shamt, alu_result,
    input  alu_sel, alu_a, alu_b, alu_ctr, stall, busy, done, result
  );

  modport slave (
    input  start, sll_flag, operand, shamt, alu_result,
    output alu_sel, alu_a, alu_b, alu_ctr, stall, busy, done, result
  );
endinterface

// File: rtl/sll_sequencer.sv
// Purpose: runs sll on the shared adder-only ALU by adding the accumulator to itself shamt times.
// Latency: accept at edge E0, done pulses in the cycle after edge E0+shamt (shamt+1 cycles later).
// Backpressure: stall holds the PC/regfile from the accepting cycle through the last SHIFT cycle.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : slave side of sll_sequencer_if (request in, borrowed ALU out/in, stall/done/result out)
module sll_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  sll_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept;
  logic               alu_sel;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [3:0]         alu_ctr;
  logic               stall;
  logic               done;

  // A start is only taken in IDLE; starts in SHIFT/DONE are dropped.
  assign accept = (state_q == IDLE) && bus.start && bus.sll_flag;

  always_comb begin
    state_d = state_q;
    alu_sel = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = 4'b0000;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall combinationally so the accepting cycle does not advance the PC.
        if (accept) begin
          stall   = 1'b1;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // acc + acc is a left shift by one on an adder-only ALU.
        alu_sel = 1'b1;
        alu_a   = acc_q;
        alu_b   = acc_q;
        alu_ctr = ALU_ADD;
        stall   = 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Stall is released here so writeback and PC advance happen together.
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q <= bus.operand;
            cnt_q <= bus.shamt;
            if (bus.shamt == '0) begin
              result_q <= bus.operand;
            end
          end
        end
        SHIFT: begin
          acc_q <= bus.alu_result;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            result_q <= bus.alu_result;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.alu_sel = alu_sel;
  assign bus.alu_a   = alu_a;
  assign bus.alu_b   = alu_b;
  assign bus.alu_ctr = alu_ctr;
  assign bus.stall   = stall;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_sll_sequencer.sv
// Purpose: directed bench for sll_sequencer with a cycle-level reference model and literal result checks.
// Latency: n/a (bench).
// Backpressure: n/a (bench); the bench plays control unit, datapath and ALU.
module tb_sll_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_abs  = 0;

  sll_sequencer_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  sll_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_abs <= cyc_abs + 1;

  // Shared ALU: adds only when the sequencer owns it with the add code;
  // otherwise the "normal datapath" feeds an unrelated value.
  assign bus.alu_result = bus.alu_sel ?
                          ((bus.alu_ctr == 4'b0010) ? bus.alu_a + bus.alu_b : 32'h0BAD_0BAD) :
                          32'h1357_9BDF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: m_left counts the busy cycles still to come after an
  // accept (shamt SHIFT cycles plus the DONE cycle); the result is just op << shamt.
  int          m_left = 0;
  logic [31:0] m_op   = '0;
  logic [4:0]  m_n    = '0;
  logic [31:0] m_res  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_op   <= '0;
      m_n    <= '0;
      m_res  <= '0;
    end else if (m_left == 0) begin
      if (bus.start && bus.sll_flag) begin
        m_op   <= bus.operand;
        m_n    <= bus.shamt;
        m_left <= int'(bus.shamt) + 1;
        if (bus.shamt == 5'd0) m_res <= bus.operand;
      end
    end else begin
      if (m_left == 2) m_res <= m_op << m_n;
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_a;
    logic        e_stall;
    e_a     = (m_left > 1) ? (m_op << (int'(m_n) + 1 - m_left)) : 32'h0;
    e_stall = ((m_left == 0) && bus.start && bus.sll_flag) || (m_left > 1);
    chk("m_stall",   32'(bus.stall),   32'(e_stall));
    chk("m_busy",    32'(bus.busy),    32'(m_left != 0));
    chk("m_done",    32'(bus.done),    32'(m_left == 1));
    chk("m_alu_sel", 32'(bus.alu_sel), 32'(m_left > 1));
    chk("m_alu_a",   bus.alu_a,        e_a);
    chk("m_alu_b",   bus.alu_b,        e_a);
    chk("m_alu_ctr", 32'(bus.alu_ctr), (m_left > 1) ? 32'h2 : 32'h0);
    chk("m_result",  bus.result,       m_res);
  end

  // Issue one sll at posedge+1 and follow it to its done pulse. A nonzero
  // poke injects an illegal start (different operand) in that cycle number.
  task automatic run_sll(input logic [31:0] op, input logic [4:0] sh,
                         input logic [31:0] exp_res, input int exp_cyc,
                         input int poke, output int done_at);
    int seen;
    int nsel;
    int cyc;
    seen = 0; nsel = 0; cyc = 0; done_at = -1;
    bus.operand  = op;
    bus.shamt    = sh;
    bus.start    = 1'b1;
    bus.sll_flag = 1'b1;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.sll_flag = 1'b0;
    bus.operand  = 32'hA5A5_A5A5;
    bus.shamt    = 5'd17;
    for (int i = 1; i <= 70 && seen == 0; i++) begin
      @(negedge clk); #2;
      cyc = i;
      if (bus.alu_sel) nsel++;
      if (bus.done) begin
        seen    = 1;
        done_at = cyc_abs;
      end
      if (i == poke) begin
        bus.start    = 1'b1;
        bus.sll_flag = 1'b1;
        bus.operand  = 32'h0000_FFFF;
        bus.shamt    = 5'd7;
      end else begin
        bus.start    = 1'b0;
        bus.sll_flag = 1'b0;
      end
    end
    chk("done_seen",   32'(seen), 32'd1);
    chk("done_cycle",  32'(cyc),  32'(exp_cyc));
    chk("result",      bus.result, exp_res);
    chk("alu_sel_cyc", 32'(nsel), 32'(sh));
    @(posedge clk); #1;
  endtask

  initial begin
    int t0;
    int t1;
    bus.start    = 1'b0;
    bus.sll_flag = 1'b0;
    bus.operand  = '0;
    bus.shamt    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    chk("rst_stall",   32'(bus.stall),   32'd0);
    chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("rst_result",  bus.result,       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Gating: start without sll_flag does nothing
    bus.start = 1'b1; bus.sll_flag = 1'b0; bus.operand = 32'h1; bus.shamt = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("gate_stall", 32'(bus.stall), 32'd0);
      chk("gate_busy",  32'(bus.busy),  32'd0);
      chk("gate_done",  32'(bus.done),  32'd0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;

    run_sll(32'h0000_0001, 5'd4,  32'h0000_0010, 5,  0, t0);
    run_sll(32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1,  0, t0);
    run_sll(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 32, 0, t0);
    run_sll(32'h8000_0001, 5'd1,  32'h0000_0002, 2,  0, t0);
    run_sll(32'h0000_0003, 5'd2,  32'h0000_000C, 3,  1, t0);

    // Reset in the 2nd SHIFT cycle of a shamt=5 operation
    bus.operand = 32'h0000_1234; bus.shamt = 5'd5; bus.start = 1'b1; bus.sll_flag = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.sll_flag = 1'b0;
    @(negedge clk);
    @(negedge clk); #2;
    chk("pre_rst_alu_sel", 32'(bus.alu_sel), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_alu_sel", 32'(bus.alu_sel), 32'd0);
    chk("arst_alu_a",   bus.alu_a,        32'd0);
    chk("arst_alu_b",   bus.alu_b,        32'd0);
    chk("arst_alu_ctr", 32'(bus.alu_ctr), 32'd0);
    chk("arst_stall",   32'(bus.stall),   32'd0);
    chk("arst_busy",    32'(bus.busy),    32'd0);
    chk("arst_done",    32'(bus.done),    32'd0);
    chk("arst_result",  bus.result,       32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("arst_hold_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sll(32'h0000_0001, 5'd1, 32'h0000_0002, 2, 0, t0);

    // Back-to-back: second issue in the first IDLE cycle after DONE
    run_sll(32'h0000_0005, 5'd1, 32'h0000_000A, 2, 0, t0);
    run_sll(32'h0000_0001, 5'd2, 32'h0000_0004, 3, 0, t1);
    chk("b2b_gap", 32'(t1 - t0), 32'd4);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
